// File: rtl/synth_pkg.sv
//------------------------------------------------------------------------------
// Module : synth_pkg
// Brief  : Shared voice/note dimensions and mixer state encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package synth_pkg;
    localparam int NUM_NOTES       = 24;
    localparam int NUM_VOICES      = 8;
    localparam int NUM_NOTES_WIDTH = 5;

    localparam logic [NUM_NOTES_WIDTH-1:0] INVALID_IDX = '1;
    localparam int SILENCE = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mixer_state_t;
endpackage

`default_nettype wire

// File: rtl/pipe_delay.sv
//------------------------------------------------------------------------------
// Module : pipe_delay
// Brief  : DEPTH-stage shift register with synchronous clear.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/voice_mixer.sv
//------------------------------------------------------------------------------
// Module : voice_mixer
// Brief  : Per-strike wavetable read of every voice slot, summed and scaled.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module voice_mixer
    import synth_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_NOTES       = synth_pkg::NUM_NOTES,
    parameter int NUM_VOICES      = synth_pkg::NUM_VOICES,
    parameter int NUM_NOTES_WIDTH = synth_pkg::NUM_NOTES_WIDTH,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       sample_trigger_in,
    input  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]       addr_in,
    input  logic [NUM_VOICES-1:0][NUM_NOTES_WIDTH-1:0] active_voices_idx_in,
    output logic [ADDR_WIDTH-1:0]                      bram_addr_out,
    input  logic [DATA_WIDTH-1:0]                      bram_data_in,
    output logic [DATA_WIDTH-1:0]                      mix_out,
    output logic                                       mix_valid_out,
    output logic                                       busy_out,
    output logic                                       overrun_out
);

    localparam int C_LOG2_V  = $clog2(NUM_VOICES);
    localparam int C_ACC_W   = DATA_WIDTH + C_LOG2_V;
    localparam int C_CNT_MAX = (NUM_VOICES > BRAM_LATENCY) ? NUM_VOICES : BRAM_LATENCY;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX) + 1;
    localparam logic [DATA_WIDTH-1:0] C_SILENCE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mixer_state_t r_state, w_next_state;
    logic [C_CNT_W-1:0]                     r_cnt;
    logic [NUM_VOICES-1:0]                  r_valid;
    logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]  r_addr;
    logic [C_ACC_W-1:0]                     r_acc;
    logic [ADDR_WIDTH-1:0]                  r_bram_addr;
    logic [DATA_WIDTH-1:0]                  r_mix;
    logic                                   r_mix_valid;
    logic                                   r_busy;
    logic                                   r_overrun;

    logic [NUM_VOICES-1:0]                  w_snap_valid;
    logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]  w_snap_addr;
    logic                                   w_accept;
    logic                                   w_last_issue;
    logic                                   w_last_drain;
    logic [C_LOG2_V-1:0]                    w_slot;
    logic [C_LOG2_V-1:0]                    w_slot_next;
    logic [1:0]                             w_tag_in;
    logic [1:0]                             w_tag_out;
    logic [DATA_WIDTH-1:0]                  w_sample;
    logic [C_ACC_W-1:0]                     w_acc_next;

    // Slot snapshot: any index outside the note range is an empty slot.
    always_comb begin
        w_snap_valid = '0;
        w_snap_addr  = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            for (int n = 0; n < NUM_NOTES; n++) begin
                if (active_voices_idx_in[k] == NUM_NOTES_WIDTH'(n)) begin
                    w_snap_valid[k] = 1'b1;
                    w_snap_addr[k]  = addr_in[n];
                end
            end
        end
    end

    assign w_accept     = (r_state == ST_IDLE) && sample_trigger_in;
    assign w_last_issue = (r_cnt == C_CNT_W'(NUM_VOICES - 1));
    assign w_last_drain = (r_cnt == C_CNT_W'(BRAM_LATENCY - 1));
    assign w_slot       = r_cnt[C_LOG2_V-1:0];
    assign w_slot_next  = w_slot + C_LOG2_V'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (sample_trigger_in) w_next_state = ST_ISSUE;
            ST_ISSUE: if (w_last_issue)      w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_last_drain)      w_next_state = ST_DONE;
            ST_DONE:                         w_next_state = ST_IDLE;
            default:                         w_next_state = ST_IDLE;
        endcase
    end

    // Tag = {slot in flight, slot valid}, aligned with the returning BRAM data.
    assign w_tag_in = {(r_state == ST_ISSUE), r_valid[w_slot]};

    pipe_delay #(
        .DEPTH (BRAM_LATENCY),
        .WIDTH (2)
    ) u_tag_pipe (
        .clk  (clk_in),
        .clr  (rst_in),
        .din  (w_tag_in),
        .dout (w_tag_out)
    );

    assign w_sample   = w_tag_out[0] ? bram_data_in : C_SILENCE;
    assign w_acc_next = w_tag_out[1] ? (r_acc + C_ACC_W'(w_sample)) : r_acc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_valid     <= '0;
            r_addr      <= '0;
            r_acc       <= '0;
            r_bram_addr <= '0;
            r_mix       <= C_SILENCE;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_mix_valid <= (w_next_state == ST_DONE);
            if (sample_trigger_in && r_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_valid     <= w_snap_valid;
                r_addr      <= w_snap_addr;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_bram_addr <= w_snap_addr[0];
            end else begin
                r_acc <= w_acc_next;
                case (r_state)
                    ST_ISSUE: begin
                        if (w_last_issue) begin
                            r_cnt       <= '0;
                            r_bram_addr <= '0;
                        end else begin
                            r_cnt       <= r_cnt + C_CNT_W'(1);
                            r_bram_addr <= r_addr[w_slot_next];
                        end
                    end
                    ST_DRAIN: begin
                        r_cnt       <= w_last_drain ? '0 : (r_cnt + C_CNT_W'(1));
                        r_bram_addr <= '0;
                    end
                    default: r_bram_addr <= '0;
                endcase
            end
            // Final slot lands in the same cycle the FSM enters DONE.
            if (w_next_state == ST_DONE) begin
                r_mix <= w_acc_next[C_ACC_W-1 -: DATA_WIDTH];
            end
        end
    end

    assign bram_addr_out = r_bram_addr;
    assign mix_out       = r_mix;
    assign mix_valid_out = r_mix_valid;
    assign busy_out      = r_busy;
    assign overrun_out   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_voice_mixer.sv
//------------------------------------------------------------------------------
// Module : tb_voice_mixer
// Brief  : Directed scoreboard bench for voice_mixer with a 2-cycle BRAM model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_voice_mixer;
    import synth_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NN = 24;
    localparam int NV = 8;
    localparam int NW = 5;
    localparam int BL = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   trig = 1'b0;
    logic [NN-1:0][AW-1:0]  addr;
    logic [NV-1:0][NW-1:0]  idx;
    logic [AW-1:0]          baddr;
    logic [DW-1:0]          bdata = '0;
    logic [DW-1:0]          mix;
    logic                   mvalid;
    logic                   busy;
    logic                   ovr;

    voice_mixer #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .NUM_NOTES       (NN),
        .NUM_VOICES      (NV),
        .NUM_NOTES_WIDTH (NW),
        .BRAM_LATENCY    (BL)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .sample_trigger_in    (trig),
        .addr_in              (addr),
        .active_voices_idx_in (idx),
        .bram_addr_out        (baddr),
        .bram_data_in         (bdata),
        .mix_out              (mix),
        .mix_valid_out        (mvalid),
        .busy_out             (busy),
        .overrun_out          (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: identity (data = addr) or a constant, two-cycle read latency.
    logic          ident = 1'b1;
    logic [DW-1:0] konst = '0;
    logic [DW-1:0] d1 = '0;
    always @(posedge clk) begin
        d1    <= ident ? DW'(baddr) : konst;
        bdata <= d1;
    end

    int checks   = 0;
    int failures = 0;
    int t0       = 0;
    int sb_val[$];
    int sb_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < t0 + c) step();
    endtask

    task automatic fire();
        trig = 1'b1;
        t0   = cyc;
        step();
        trig = 1'b0;
    endtask

    task automatic expect_mix(input int v);
        sb_val.push_back(v);
        sb_cyc.push_back(t0 + NV + BL + 1);
    endtask

    always @(negedge clk) begin
        if (mvalid === 1'b1) begin
            if (sb_val.size() == 0) begin
                check("unexpected_valid", {31'd0, mvalid}, 32'd0);
            end else begin
                check("mix_value", mix, sb_val.pop_front());
                check("mix_cycle", cyc, sb_cyc.pop_front());
            end
        end
    end

    initial begin
        addr = '0;
        for (int k = 0; k < NV; k++) idx[k] = INVALID_IDX;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        check("rst_mix", mix, SILENCE);
        check("rst_valid", mvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", ovr, 0);
        check("rst_addr", baddr, 0);
        step();

        // All slots empty
        fire();
        expect_mix(128);
        check("busy_c1", busy, 1);
        for (int c = 1; c <= 11; c++) begin
            wait_to(c);
            check("addr_empty", baddr, 0);
        end
        wait_to(12);
        check("busy_c12", busy, 0);

        // One voice, identity BRAM, input changes after snapshot ignored
        idx[0]  = 5'd3;
        addr[3] = 8'h40;
        ident   = 1'b1;
        fire();
        expect_mix(120);
        check("addr_slot0", baddr, 8'h40);
        wait_to(2);
        addr[3] = 8'hFF;
        wait_to(12);

        // Eight valid voices
        for (int k = 0; k < NV; k++) begin
            idx[k]  = NW'(k);
            addr[k] = AW'(8'h10 + k);
        end
        ident = 1'b0;
        konst = 8'd255;
        fire();
        expect_mix(255);
        for (int c = 1; c <= 9; c++) begin
            wait_to(c);
            check("addr_order", baddr, (c <= NV) ? 32'(8'h10 + c - 1) : 32'd0);
        end
        wait_to(12);
        konst = 8'd0;
        fire();
        expect_mix(0);
        wait_to(12);
        ident = 1'b1;
        fire();
        expect_mix(19);
        wait_to(12);

        // Overrun: trigger while busy, then back-to-back at min spacing
        ident = 1'b0;
        konst = 8'd255;
        fire();
        expect_mix(255);
        wait_to(5);
        check("ovr_c5", ovr, 0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        check("ovr_c6", ovr, 1);
        wait_to(11);
        check("busy_done", busy, 1);
        wait_to(12);
        fire();
        expect_mix(255);
        wait_to(12);
        check("ovr_sticky", ovr, 1);

        // Reset mid-mix aborts with no valid pulse
        fire();
        wait_to(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mix", mix, SILENCE);
        check("abort_ovr", ovr, 0);
        check("abort_addr", baddr, 0);
        wait_to(16);
        konst = 8'd0;
        fire();
        expect_mix(0);
        wait_to(12);

        check("scoreboard_empty", sb_val.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
